// File: rtl/mmio_display_out_if.sv
// Data-bus write path seen by store-side MMIO peripherals.
//   addr   : 32-bit byte address of the store
//   we     : store strobe, high for one cycle per store
//   wdata  : 32-bit store data
// The CPU side uses the master modport; peripherals use the slave modport.
// There is no read data here because the peripherals on this path are write-only.
interface mmio_display_out_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;

  modport master (output addr, output we, output wdata);
  modport slave  (input  addr, input  we, input  wdata);
endinterface

// File: rtl/mmio_display_out.sv
// Store-side MMIO display peripheral.
// CPU stores load a 32-bit value shown as 8 hex digits on a multiplexed
// seven-segment display, and a 24-bit LED register. Nothing here is readable.
// Ports:
//   clk     : system clock, all state updates on the rising edge
//   rst     : synchronous reset, active-high
//   bus     : store bus (addr, we, wdata), slave side
//   dig_en  : digit enables, active-low, bit i = digit i (0 = rightmost)
//   seg     : segments {dp,g,f,e,d,c,b,a}, active-low, dp held off
//   led     : LED drive, active-high
module mmio_display_out #(
  parameter logic [31:0] DIG_ADDR = 32'hFFFF_F000,
  parameter logic [31:0] LED_ADDR = 32'hFFFF_F060,
  parameter int          SCAN_DIV = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_display_out_if.slave    bus,
  output logic [7:0]           dig_en,
  output logic [7:0]           seg,
  output logic [23:0]          led
);

  localparam int                CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [31:0]      value_q,  value_d;
  logic [23:0]      led_q,    led_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       idx_q,    idx_d;
  logic [7:0]       dig_en_q, dig_en_d;
  logic [7:0]       seg_q,    seg_d;

  // Hex nibble to active-low segment pattern, dp bit included and held off.
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 8'hC0;
      4'h1:    hex7 = 8'hF9;
      4'h2:    hex7 = 8'hA4;
      4'h3:    hex7 = 8'hB0;
      4'h4:    hex7 = 8'h99;
      4'h5:    hex7 = 8'h92;
      4'h6:    hex7 = 8'h82;
      4'h7:    hex7 = 8'hF8;
      4'h8:    hex7 = 8'h80;
      4'h9:    hex7 = 8'h90;
      4'hA:    hex7 = 8'h88;
      4'hB:    hex7 = 8'h83;
      4'hC:    hex7 = 8'hC6;
      4'hD:    hex7 = 8'hA1;
      4'hE:    hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    value_d  = value_q;
    led_d    = led_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;

    // Exact full-address decode; anything else on the bus is ignored.
    if (bus.we && (bus.addr == DIG_ADDR)) value_d = bus.wdata;
    if (bus.we && (bus.addr == LED_ADDR)) led_d   = bus.wdata[23:0];

    // Scan timing is free-running and independent of stores.
    // idx is 3 bits, so 7 + 1 wraps to 0 by itself.
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end

    // Output stage looks at the current idx/value, so the pins lag by one cycle.
    dig_en_d = ~(8'b1 << idx_q);
    seg_d    = hex7(value_q[{idx_q, 2'b00} +: 4]);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      led_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      dig_en_q <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      value_q  <= value_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dig_en_q <= dig_en_d;
      seg_q    <= seg_d;
    end
  end

  assign dig_en = dig_en_q;
  assign seg    = seg_q;
  assign led    = led_q;

endmodule
